bus_burst_responder: RTL and testbench

//  Bus-slave end of the shared burst bus that the DMA custom instruction drives as initiator.

---
 rtl/bus_burst_responder_if.sv | 28 ++
 rtl/bus_burst_responder.sv | 149 ++++++++++++++
 tb/tb_bus_burst_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_burst_responder_if.sv
// Burst bus seen from one responder: initiator-driven request/write-data signals
// and responder-driven read-data/status signals.
interface bus_burst_responder_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        readNotWriteIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busyOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
               readNotWriteIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );

    modport slave (
        input  beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
               readNotWriteIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );
endinterface

// File: rtl/bus_burst_responder.sv
// Burst-bus slave holding a word-addressed RAM window. Answers read and write
// bursts; every bus output is registered and held at 0 while idle so several
// responders can be wire-ORed onto the same bus.
//
// Handshake: a transaction starts when beginTransactionIn is seen in IDLE with
// a selected address. Write words are taken on any WR_DATA cycle where
// dataValidIn=1 and busyOut=0; while busyOut=1 the initiator holds its word and
// re-presents it. Read words are offered on consecutive cycles with
// dataValidOut=1 (no back-pressure), closed by a one-cycle endTransactionOut.
module bus_burst_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h5000_0000,
    parameter int          ADDR_WORDS_LOG2 = 10,
    parameter int          STALL_PERIOD    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_burst_responder_if.slave  bus,
    output logic [2:0]            fsm_state
);
    localparam int AW      = ADDR_WORDS_LOG2;
    localparam int WORDS   = 1 << AW;
    localparam int TAG_LSB = AW + 2;
    localparam logic [15:0] STALL_LAST = 16'(STALL_PERIOD > 0 ? STALL_PERIOD - 1 : 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FETCH = 3'd1,
        RD_DATA  = 3'd2,
        RD_END   = 3'd3,
        WR_DATA  = 3'd4,
        ERR      = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [7:0]    cnt;
    logic [7:0]    burst_q;
    logic [3:0]    be_q;
    logic [8:0]    wr_count;
    logic [15:0]   stall_cnt;
    logic [31:0]   rdata;
    logic [31:0]   mem [WORDS];

    logic selected;
    logic take_word;
    logic in_burst;
    logic wr_en;
    logic stall_hit;

    assign fsm_state = state;

    // Address decode, write acceptance and stall detection
    always_comb begin
        selected  = (bus.addressDataIn[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
        take_word = (state == WR_DATA) && bus.dataValidIn && !bus.busyOut;
        in_burst  = (wr_count <= {1'b0, burst_q});
        wr_en     = take_word && in_burst && !reset;
        stall_hit = (STALL_PERIOD > 0) && (stall_cnt == STALL_LAST);
    end

    // RAM: byte-lane writes, registered read of the current index (not reset)
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
            end
        end
        rdata <= mem[idx];
    end

    // Transaction FSM with registered, idle-zero bus outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= IDLE;
            idx                   <= '0;
            cnt                   <= '0;
            burst_q               <= '0;
            be_q                  <= '0;
            wr_count              <= '0;
            stall_cnt             <= '0;
            bus.addressDataOut    <= '0;
            bus.dataValidOut      <= 1'b0;
            bus.endTransactionOut <= 1'b0;
            bus.busyOut           <= 1'b0;
            bus.busErrorOut       <= 1'b0;
        end else begin
            bus.addressDataOut    <= '0;
            bus.dataValidOut      <= 1'b0;
            bus.endTransactionOut <= 1'b0;
            bus.busyOut           <= 1'b0;
            bus.busErrorOut       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.beginTransactionIn && selected) begin
                        idx       <= bus.addressDataIn[AW+1:2];
                        cnt       <= bus.burstSizeIn;
                        burst_q   <= bus.burstSizeIn;
                        be_q      <= bus.byteEnablesIn;
                        wr_count  <= '0;
                        stall_cnt <= '0;
                        if (bus.addressDataIn[1:0] != 2'b00) state <= ERR;
                        else if (bus.readNotWriteIn)         state <= RD_FETCH;
                        else                                 state <= WR_DATA;
                    end
                end
                RD_FETCH: begin
                    // first word is being read into rdata this cycle
                    idx   <= idx + AW'(1);
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    bus.dataValidOut   <= 1'b1;
                    bus.addressDataOut <= rdata;
                    idx                <= idx + AW'(1);
                    if (cnt == 8'd0) state <= RD_END;
                    else             cnt   <= cnt - 8'd1;
                end
                RD_END: begin
                    bus.endTransactionOut <= 1'b1;
                    state                 <= IDLE;
                end
                WR_DATA: begin
                    if (take_word) begin
                        if (in_burst) begin
                            idx      <= idx + AW'(1);
                            wr_count <= wr_count + 9'd1;
                            if (stall_hit) begin
                                stall_cnt <= '0;
                                // no stall once the burst is closing
                                bus.busyOut <= !bus.endTransactionIn;
                            end else begin
                                stall_cnt <= stall_cnt + 16'd1;
                            end
                        end else begin
                            bus.busErrorOut <= 1'b1;
                        end
                    end
                    if (bus.endTransactionIn) state <= IDLE;
                end
                ERR: begin
                    bus.busErrorOut       <= 1'b1;
                    bus.endTransactionOut <= 1'b1;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_burst_responder.sv
// Directed bench for bus_burst_responder built with a stall period of 2.
module tb_bus_burst_responder;
    localparam logic [31:0] BASE = 32'h5000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] fsm_state;
    int         checks = 0;
    int         errors = 0;
    int         err_cnt;
    logic [6:0] busy_hist;
    logic [31:0] exp_q[$];
    logic [31:0] wr_q[$];

    bus_burst_responder_if bus_if ();

    bus_burst_responder #(
        .BASE_ADDR(BASE), .ADDR_WORDS_LOG2(10), .STALL_PERIOD(2)
    ) dut (
        .clock(clk), .reset(rst), .bus(bus_if.slave), .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flags"}, {28'd0, bus_if.dataValidOut, bus_if.endTransactionOut,
                                bus_if.busyOut, bus_if.busErrorOut}, 32'd0);
        check({tag, "_data"}, bus_if.addressDataOut, 32'd0);
    endtask

    task automatic begin_txn(input logic [31:0] addr, input logic rnw,
                             input logic [7:0] burst, input logic [3:0] be);
        bus_if.beginTransactionIn = 1'b1;
        bus_if.addressDataIn      = addr;
        bus_if.readNotWriteIn     = rnw;
        bus_if.burstSizeIn        = burst;
        bus_if.byteEnablesIn      = be;
        tick();
        bus_if.beginTransactionIn = 1'b0;
        bus_if.addressDataIn      = '0;
    endtask

    // Write burst driver: words come from wr_q; a word is re-presented while busyOut=1
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] burst,
                               input logic [3:0] be, input logic end_same);
        int n;
        int holds;
        logic held;
        n = wr_q.size();
        err_cnt = 0;
        busy_hist = '0;
        begin_txn(addr, 1'b0, burst, be);
        for (int i = 0; i < n; i++) begin
            bus_if.dataValidIn   = 1'b1;
            bus_if.addressDataIn = wr_q.pop_front();
            if (end_same && i == n - 1) bus_if.endTransactionIn = 1'b1;
            holds = 0;
            do begin
                held = bus_if.busyOut;
                busy_hist = {busy_hist[5:0], held};
                tick();
                if (bus_if.busErrorOut) err_cnt++;
                holds++;
                if (holds > 4) begin
                    check("busy_stuck", 32'd1, 32'd0);
                    held = 1'b0;
                end
            end while (held);
        end
        bus_if.dataValidIn   = 1'b0;
        bus_if.addressDataIn = '0;
        if (!end_same) begin
            bus_if.endTransactionIn = 1'b1;
            tick();
            if (bus_if.busErrorOut) err_cnt++;
        end
        bus_if.endTransactionIn = 1'b0;
    endtask

    // Read burst with cycle-exact checks; expected words come from exp_q
    task automatic read_burst(input string tag, input logic [31:0] addr, input logic [7:0] burst);
        begin_txn(addr, 1'b1, burst, 4'h0);
        tick();
        check({tag, "_t1_valid"}, {31'd0, bus_if.dataValidOut}, 32'd0);
        for (int k = 0; k <= int'(burst); k++) begin
            tick();
            check({tag, "_valid"}, {31'd0, bus_if.dataValidOut}, 32'd1);
            check({tag, "_word"}, bus_if.addressDataOut, exp_q.pop_front());
        end
        tick();
        check({tag, "_end"}, {30'd0, bus_if.endTransactionOut, bus_if.dataValidOut}, 32'd2);
        check({tag, "_end_data"}, bus_if.addressDataOut, 32'd0);
        tick();
        check({tag, "_after_end"}, {29'd0, fsm_state}, 32'd0);
        check_quiet({tag, "_after"});
    endtask

    initial begin
        bus_if.beginTransactionIn = 1'b0;
        bus_if.addressDataIn      = '0;
        bus_if.byteEnablesIn      = '0;
        bus_if.burstSizeIn        = '0;
        bus_if.readNotWriteIn     = 1'b0;
        bus_if.dataValidIn        = 1'b0;
        bus_if.endTransactionIn   = 1'b0;

        // reset held for two cycles
        tick();
        tick();
        check_quiet("reset");
        check("reset_state", {29'd0, fsm_state}, 32'd0);
        rst = 1'b0;
        tick();

        // write burst of 33,43,53 to words 4..6 (stall after 2nd word)
        wr_q = '{32'd33, 32'd43, 32'd53};
        begin
            int n;
            logic held;
            n = 0;
            begin_txn(BASE + 32'h10, 1'b0, 8'd2, 4'hF);
            busy_hist = '0;
            while (n < 3) begin
                bus_if.dataValidIn   = 1'b1;
                bus_if.addressDataIn = wr_q[n];
                held = bus_if.busyOut;
                busy_hist = {busy_hist[5:0], held};
                tick();
                if (!held) n++;
                if (busy_hist == 7'h7F) n = 3;
            end
            bus_if.dataValidIn = 1'b0;
            check("wr_state_open", {29'd0, fsm_state}, 32'd4);
            check("wr_busy_hist", {25'd0, busy_hist}, 32'h0000_0002);
            bus_if.endTransactionIn = 1'b1;
            tick();
            bus_if.endTransactionIn = 1'b0;
            check("wr_end_idle", {29'd0, fsm_state}, 32'd0);
            wr_q.delete();
        end

        // read burst of words 4..6
        exp_q = '{32'd33, 32'd43, 32'd53};
        read_burst("rd", BASE + 32'h10, 8'd2);

        // reset asserted during RD_DATA aborts with no end pulse
        begin_txn(BASE + 32'h10, 1'b1, 8'd2, 4'h0);
        tick();
        tick();
        check("rst_mid_valid", {31'd0, bus_if.dataValidOut}, 32'd1);
        check("rst_mid_word", bus_if.addressDataOut, 32'd33);
        rst = 1'b1;
        tick();
        check_quiet("rst_mid");
        check("rst_mid_state", {29'd0, fsm_state}, 32'd0);
        rst = 1'b0;
        tick();
        check_quiet("rst_mid_after");

        // stall period 2 over a 5-word burst; word 37 guards against a double write
        wr_q = '{32'hDEAD_0037};
        write_burst(BASE + 32'h94, 8'd0, 4'hF, 1'b0);
        wr_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104};
        write_burst(BASE + 32'h80, 8'd4, 4'hF, 1'b0);
        check("stall_hist", {25'd0, busy_hist}, 32'h0000_0012);
        check("stall_no_err", err_cnt, 32'd0);
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'hDEAD_0037};
        read_burst("stall_rd", BASE + 32'h80, 8'd5);

        // unaligned begin address -> one-cycle error with end
        begin_txn(BASE + 32'h2, 1'b1, 8'd0, 4'h0);
        check("unal_t0", {30'd0, bus_if.busErrorOut, bus_if.endTransactionOut}, 32'd0);
        tick();
        check("unal_t1", {30'd0, bus_if.busErrorOut, bus_if.endTransactionOut}, 32'd3);
        tick();
        check_quiet("unal_t2");
        check("unal_idle", {29'd0, fsm_state}, 32'd0);

        // address outside the window: no response at all
        begin_txn(32'h5000_1010, 1'b1, 8'd2, 4'h0);
        for (int k = 0; k < 4; k++) begin
            check_quiet("unsel_rd");
            check("unsel_state", {29'd0, fsm_state}, 32'd0);
            tick();
        end
        wr_q = '{32'h0000_0BAD};
        write_burst(32'h5000_1010, 8'd0, 4'hF, 1'b0);
        exp_q = '{32'd33};
        read_burst("unsel_keep", BASE + 32'h10, 8'd0);

        // overrun: burst=1 with 3 words -> 3rd dropped with an error pulse
        wr_q = '{32'h0000_1818};
        write_burst(BASE + 32'h48, 8'd0, 4'hF, 1'b0);
        wr_q = '{32'hA0, 32'hA1, 32'hA2};
        write_burst(BASE + 32'h40, 8'd1, 4'hF, 1'b0);
        check("ovr_err_pulses", err_cnt, 32'd1);
        exp_q = '{32'hA0, 32'hA1, 32'h0000_1818};
        read_burst("ovr_rd", BASE + 32'h40, 8'd2);

        // wrap from the top word to word 0, then a lower-lane-only write
        wr_q = '{32'hAAAA_BBBB, 32'hCCCC_DDDD};
        write_burst(BASE + 32'hFFC, 8'd1, 4'hF, 1'b0);
        wr_q = '{32'h1111_2222, 32'h3333_4444};
        write_burst(BASE + 32'hFFC, 8'd1, 4'b0011, 1'b1);
        check("lane_end_same_idle", {29'd0, fsm_state}, 32'd0);
        check("lane_no_busy", {31'd0, bus_if.busyOut}, 32'd0);
        exp_q = '{32'hAAAA_2222, 32'hCCCC_4444};
        read_burst("wrap_rd", BASE + 32'hFFC, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
